// File: rtl/rs_pkg.sv
`default_nettype none
// rs_pkg: shared FSM state type and counter-width helper for the RS cell drive controller.
package rs_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PULSE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } rs_drv_state_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_drive_ctrl_if.sv
`default_nettype none
// rs_drive_ctrl_if: request handshake, RS cell drive/readback and completion signals.
interface rs_drive_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_mask;
  logic [WIDTH-1:0] req_value;
  logic [WIDTH-1:0] s_out;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] q_in;
  logic             done_valid;
  logic             done_err;
  logic [WIDTH-1:0] done_mismatch;

  // master: requester plus cell bank; slave: the drive controller.
  modport master (
    output req_valid, req_mask, req_value, q_in,
    input  req_ready, s_out, r_out, done_valid, done_err, done_mismatch
  );

  modport slave (
    input  req_valid, req_mask, req_value, q_in,
    output req_ready, s_out, r_out, done_valid, done_err, done_mismatch
  );
endinterface
`default_nettype wire

// File: rtl/rs_pulse_timer.sv
`default_nettype none
// rs_pulse_timer: loadable down-counter with zero flag, shared by the pulse and settle phases.
module rs_pulse_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/rs_drive_ctrl.sv
`default_nettype none
// rs_drive_ctrl: drives masked set/reset pulses into an RS cell bank, reads back,
// retries failed bits and reports the outcome with a one-cycle done strobe.
module rs_drive_ctrl
  import rs_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int PULSE_CYCLES  = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  rs_drive_ctrl_if.slave bus
);

  localparam int RW = cnt_width(MAX_RETRY);
  localparam int TW = cnt_width((PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  // Timer is loaded with N-1 so the phase lasts N cycles including the zero cycle.
  localparam logic [TW-1:0] PULSE_LOAD  = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  rs_drv_state_t    state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] s_out_q, s_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic [WIDTH-1:0] mismatch_q, mismatch_d;
  logic             done_valid_q, done_valid_d;
  logic             done_err_q, done_err_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [WIDTH-1:0] miss;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_zero;

  rs_pulse_timer #(.CNT_W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    value_d      = value_q;
    pending_d    = pending_q;
    retry_d      = retry_q;
    done_valid_d = 1'b0;
    done_err_d   = 1'b0;
    mismatch_d   = '0;
    tmr_load     = 1'b0;
    tmr_val      = PULSE_LOAD;
    miss         = mask_q & (bus.q_in ^ value_q);

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          mask_d    = bus.req_mask;
          value_d   = bus.req_value;
          pending_d = bus.req_mask & (bus.q_in ^ bus.req_value);
          retry_d   = '0;
          if (pending_d == '0) begin
            state_d      = DONE;
            done_valid_d = 1'b1;
          end else begin
            state_d  = PULSE;
            tmr_load = 1'b1;
            tmr_val  = PULSE_LOAD;
          end
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (tmr_zero) state_d = CHECK;
      end
      CHECK: begin
        if (miss == '0) begin
          state_d      = DONE;
          done_valid_d = 1'b1;
        end else if (retry_q < RETRY_LIMIT) begin
          retry_d   = retry_q + 1'b1;
          pending_d = miss;
          state_d   = PULSE;
          tmr_load  = 1'b1;
          tmr_val   = PULSE_LOAD;
        end else begin
          state_d      = DONE;
          done_valid_d = 1'b1;
          done_err_d   = 1'b1;
          mismatch_d   = miss;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Drive outputs are registered off the next state so they line up with PULSE exactly.
    s_out_d = (state_d == PULSE) ? (pending_d & value_d)  : '0;
    r_out_d = (state_d == PULSE) ? (pending_d & ~value_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      value_q      <= '0;
      pending_q    <= '0;
      s_out_q      <= '0;
      r_out_q      <= '0;
      mismatch_q   <= '0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      retry_q      <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      value_q      <= value_d;
      pending_q    <= pending_d;
      s_out_q      <= s_out_d;
      r_out_q      <= r_out_d;
      mismatch_q   <= mismatch_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
      retry_q      <= retry_d;
    end
  end

  assign bus.req_ready     = (state_q == IDLE) && rst_n;
  assign bus.s_out         = s_out_q;
  assign bus.r_out         = r_out_q;
  assign bus.done_valid    = done_valid_q;
  assign bus.done_err      = done_err_q;
  assign bus.done_mismatch = mismatch_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_drive_ctrl.sv
`default_nettype none
// tb_rs_drive_ctrl: scoreboard bench with an RS cell bank model and a per-request outcome model.
module tb_rs_drive_ctrl;

  localparam int W  = 8;
  localparam int P  = 1;
  localparam int S  = 2;
  localparam int MR = 3;

  typedef struct {
    logic         err;
    logic [W-1:0] mism;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [W-1:0] q_final;
    int           acc_cyc;
    int           done_cyc;
    int           pbits;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_done = -10;
  int   pacc = 0;
  exp_t sbq[$];

  logic [W-1:0] cells = '0;
  logic [W-1:0] stuck0 = '0;
  logic [W-1:0] cur_mask = '0;
  logic         pre_en = 1'b0;
  logic [W-1:0] pre_val = '0;

  rs_drive_ctrl_if #(.WIDTH(W)) bus ();

  rs_drive_ctrl #(
    .WIDTH(W), .PULSE_CYCLES(P), .SETTLE_CYCLES(S), .MAX_RETRY(MR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cell bank: each bit is a clocked RS flop; stuck0 pins readback low.
  always @(posedge clk) begin
    if (pre_en) begin
      cells <= pre_val;
    end else begin
      for (int b = 0; b < W; b++) begin
        if (bus.s_out[b] && !bus.r_out[b])      cells[b] <= 1'b1;
        else if (bus.r_out[b] && !bus.s_out[b]) cells[b] <= 1'b0;
      end
    end
  end
  assign bus.q_in = cells & ~stuck0;

  // Outcome model: apply whole-pending-set write attempts until clean or attempts exhausted.
  function automatic exp_t model(input logic [W-1:0] q0, m, v, stuck, input int c);
    exp_t e;
    logic [W-1:0] cl, miss;
    int att, lat;
    cl = q0;
    miss = m & (cl ^ v);
    e.s = miss & v;
    e.r = miss & ~v;
    e.err = 1'b0;
    e.mism = '0;
    e.pbits = 0;
    e.acc_cyc = c + 1;
    att = 0;
    while (miss != '0 && att <= MR) begin
      e.pbits += $countones(miss) * P;
      cl = ((cl & ~miss) | (v & miss)) & ~stuck;
      miss = m & (cl ^ v);
      att++;
    end
    lat = (att == 0) ? 1 : att * (P + S + 1) + 1;
    if (miss != '0) begin
      e.err = 1'b1;
      e.mism = miss;
    end
    e.q_final = cl;
    e.done_cyc = c + lat;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: invariants every cycle, first-pulse pattern and completion checks from the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      pacc = 0;
    end else begin
      chk("s_and_r_overlap", 32'(bus.s_out & bus.r_out), 32'h0);
      chk("pulse_outside_mask", 32'((bus.s_out | bus.r_out) & ~cur_mask), 32'h0);
      pacc += $countones(bus.s_out | bus.r_out);
      if (sbq.size() > 0 && cyc == sbq[0].acc_cyc) begin
        chk("first_s_out", 32'(bus.s_out), 32'(sbq[0].s));
        chk("first_r_out", 32'(bus.r_out), 32'(sbq[0].r));
      end
      if (bus.done_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'(bus.done_valid), 32'h0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("done_err", 32'(bus.done_err), 32'(e.err));
          chk("done_mismatch", 32'(bus.done_mismatch), 32'(e.mism));
          chk("q_at_done", 32'(bus.q_in), 32'(e.q_final));
          chk("pulse_bit_cycles", 32'(pacc), 32'(e.pbits));
        end
        pacc = 0;
        last_done = cyc;
      end else if (sbq.size() > 0 && cyc > sbq[0].done_cyc) begin
        chk("done_missing", 32'(cyc), 32'(sbq[0].done_cyc));
        void'(sbq.pop_front());
      end
    end
  end

  task automatic preload(input logic [W-1:0] v);
    @(negedge clk);
    pre_val = v;
    pre_en = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] m, v, input bit exp_it, keep, b2b);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_mask = m;
    bus.req_value = v;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'(n), 32'h0);
      bus.req_valid = 1'b0;
      return;
    end
    if (b2b) chk("b2b_accept_cycle", 32'(cyc), 32'(last_done + 1));
    cur_mask = m;
    if (exp_it) sbq.push_back(model(bus.q_in, m, v, stuck0, cyc));
    @(posedge clk);
    #1;
    bus.req_mask = W'($urandom);
    bus.req_value = W'($urandom);
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      chk("drain_timeout", 32'(sbq.size()), 32'h0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  localparam int NR = 40;
  bit pre_sel[NR];

  initial begin
    bus.req_valid = 1'b1;
    bus.req_mask = 8'hFF;
    bus.req_value = 8'h5A;

    repeat (2) begin
      @(negedge clk);
      chk("rst_s_out", 32'(bus.s_out), 32'h0);
      chk("rst_r_out", 32'(bus.r_out), 32'h0);
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_done", 32'(bus.done_valid), 32'h0);
    end
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(bus.req_ready), 32'h1);

    preload(8'h00); send(8'hFF, 8'hA5, 1, 0, 0); drain();
    chk("clean_cells", 32'(bus.q_in), 32'hA5);
    preload(8'h3C); send(8'h0F, 8'h0C, 1, 0, 0); drain();
    preload(8'hF0); send(8'hFF, 8'h0F, 1, 0, 0); drain();
    preload(8'h00); send(8'h00, 8'hFF, 1, 0, 0); drain();

    stuck0 = 8'h08;
    preload(8'h00); send(8'h08, 8'h08, 1, 0, 0); drain();
    stuck0 = 8'h00;

    // Abort in the middle of a pulse.
    preload(8'h00);
    send(8'hFF, 8'hA5, 0, 0, 0);
    @(negedge clk);
    chk("pulse_before_abort", 32'(bus.s_out), 32'hA5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_s_out", 32'(bus.s_out), 32'h0);
    chk("abort_r_out", 32'(bus.r_out), 32'h0);
    chk("abort_ready", 32'(bus.req_ready), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_ready", 32'(bus.req_ready), 32'h1);
    repeat (6) @(negedge clk);

    for (int i = 0; i < NR; i++) pre_sel[i] = ($urandom_range(0, 2) == 0);
    for (int i = 0; i < NR; i++) begin
      bit keep, b2b;
      keep = (i < NR - 1) && !pre_sel[i + 1];
      b2b = (i > 0) && !pre_sel[i] && !pre_sel[i - 1];
      if (pre_sel[i]) begin
        drain();
        preload(W'($urandom));
      end
      send(W'($urandom), W'($urandom), 1, keep, b2b);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
